// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared state type, width helpers and default sizes for the cache fill controller
package cache_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_WORDS  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2
  } fill_state_e;

  // word index width inside a line
  function automatic int idx_w(input int words);
    return $clog2(words);
  endfunction

  // byte offset width inside a line
  function automatic int off_w(input int words, input int data_w);
    return $clog2(words) + $clog2(data_w / 8);
  endfunction

  // tag width left above the line offset
  function automatic int tag_w(input int addr_w, input int words, input int data_w);
    return addr_w - off_w(words, data_w);
  endfunction

endpackage

// File: rtl/line_word_counter.sv
// rtl/line_word_counter.sv - per-line word counter with sync clear and saturation at WORDS
module line_word_counter import cache_pkg::*; #(
  parameter  int WORDS = DEF_WORDS,
  localparam int CNT_W = idx_w(WORDS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS);

  // Count enabled events, holding at WORDS once the whole line has been seen
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != FULL)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - cache line fill controller; dirty-victim writeback enabled by CACHE_FILL_WB_EN
module cache_fill_fsm import cache_pkg::*; #(
  parameter  int ADDR_W = DEF_ADDR_W,
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int WORDS  = DEF_WORDS,
  localparam int IDX_W  = idx_w(WORDS),
  localparam int OFF_W  = off_w(WORDS, DATA_W),
  localparam int TAG_W  = tag_w(ADDR_W, WORDS, DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  input  logic [DATA_W-1:0] victim_data,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_wdata,
  output logic              write_data_array,
  output logic [IDX_W-1:0]  fill_word,
  output logic [IDX_W-1:0]  victim_word,
  output logic              write_tag_array,
  output logic              fill_done
);

  localparam int CNT_W  = IDX_W + 1;
  localparam int BYTE_W = OFF_W - IDX_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS);

  fill_state_e      state_q, state_d;
  logic [TAG_W-1:0] miss_tag_q;
  logic [CNT_W-1:0] iss, rcv;
  logic             start, iss_clr, iss_en, rcv_en;

`ifdef CACHE_FILL_WB_EN
  logic [TAG_W-1:0] vic_tag_q;
`endif

  // The data array consumes memory_data directly; only its strobe and index come from here
  logic unused_bits;
`ifdef CACHE_FILL_WB_EN
  assign unused_bits = ^{miss_address[OFF_W-1:0], memory_data};
`else
  assign unused_bits = ^{miss_address[OFF_W-1:0], memory_data, victim_dirty, victim_tag, victim_data};
`endif

  line_word_counter #(.WORDS(WORDS)) u_iss (
    .clk   (clk),
    .rst   (rst),
    .clr   (iss_clr),
    .en    (iss_en),
    .count (iss)
  );

  line_word_counter #(.WORDS(WORDS)) u_rcv (
    .clk   (clk),
    .rst   (rst),
    .clr   (start),
    .en    (rcv_en),
    .count (rcv)
  );

  // State register plus line tags captured in the detection cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
`ifdef CACHE_FILL_WB_EN
      vic_tag_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (start) begin
        miss_tag_q <= miss_address[ADDR_W-1:OFF_W];
`ifdef CACHE_FILL_WB_EN
        vic_tag_q  <= victim_tag;
`endif
      end
    end
  end

  // Next state, request issue and fill receive; everything held low in a reset cycle
  always_comb begin
    state_d          = state_q;
    start            = 1'b0;
    iss_clr          = 1'b0;
    iss_en           = 1'b0;
    rcv_en           = 1'b0;
    fsm_busy         = 1'b0;
    mem_enable       = 1'b0;
    mem_write        = 1'b0;
    memory_address   = '0;
    memory_wdata     = '0;
    write_data_array = 1'b0;
    fill_word        = '0;
    victim_word      = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (miss_detected) begin
            fsm_busy = 1'b1;
            start    = 1'b1;
            iss_clr  = 1'b1;
`ifdef CACHE_FILL_WB_EN
            state_d  = victim_dirty ? WB : FILL;
`else
            state_d  = FILL;
`endif
          end
        end
`ifdef CACHE_FILL_WB_EN
        WB: begin
          fsm_busy       = 1'b1;
          mem_enable     = 1'b1;
          mem_write      = 1'b1;
          victim_word    = iss[IDX_W-1:0];
          memory_wdata   = victim_data;
          memory_address = ADDR_W'({vic_tag_q, iss[IDX_W-1:0]}) << BYTE_W;
          iss_en         = 1'b1;
          if (iss == LAST) begin
            iss_clr = 1'b1;
            state_d = FILL;
          end
        end
`endif
        FILL: begin
          fsm_busy = 1'b1;
          if (iss != FULL) begin
            mem_enable     = 1'b1;
            memory_address = ADDR_W'({miss_tag_q, iss[IDX_W-1:0]}) << BYTE_W;
            iss_en         = 1'b1;
          end
          if (memory_data_valid && (rcv != FULL)) begin
            write_data_array = 1'b1;
            fill_word        = rcv[IDX_W-1:0];
            rcv_en           = 1'b1;
            if (rcv == LAST) begin
              write_tag_array = 1'b1;
              fill_done       = 1'b1;
              state_d         = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm with a schedule-level reference model
module tb_cache_fill_fsm;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WORDS  = 8;
  localparam int L      = 4;
  localparam int OFF_W  = 4;
  localparam int BYTES  = 2;
`ifdef CACHE_FILL_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, miss_detected, victim_dirty, memory_data_valid;
  logic [15:0] miss_address, memory_data, victim_data;
  logic [11:0] victim_tag;
  logic        fsm_busy, mem_enable, mem_write, write_data_array, write_tag_array, fill_done;
  logic [15:0] memory_address, memory_wdata;
  logic [2:0]  fill_word, victim_word;

  assign victim_data = 16'hD000 | {13'd0, victim_word};

  cache_fill_fsm #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS)) u_dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_data(victim_data),
    .memory_data(memory_data), .memory_data_valid(memory_data_valid),
    .fsm_busy(fsm_busy), .mem_enable(mem_enable), .mem_write(mem_write),
    .memory_address(memory_address), .memory_wdata(memory_wdata),
    .write_data_array(write_data_array), .fill_word(fill_word), .victim_word(victim_word),
    .write_tag_array(write_tag_array), .fill_done(fill_done)
  );

  // 32-bit, 4-word instance for the wide address layout
  logic        miss32, valid32, busy32, en32, wr32, wda32, wta32, done32;
  logic [31:0] addr32, maddr32, wdata32;
  logic [27:0] vtag32;
  logic [31:0] vdata32, mdata32;
  logic [1:0]  fw32, vw32;
  assign vtag32  = '0;
  assign vdata32 = '0;
  assign mdata32 = 32'h1234_5678;

  cache_fill_fsm #(.ADDR_W(32), .DATA_W(32), .WORDS(4)) u_dut32 (
    .clk(clk), .rst(rst), .miss_detected(miss32), .miss_address(addr32),
    .victim_dirty(1'b0), .victim_tag(vtag32), .victim_data(vdata32),
    .memory_data(mdata32), .memory_data_valid(valid32),
    .fsm_busy(busy32), .mem_enable(en32), .mem_write(wr32),
    .memory_address(maddr32), .memory_wdata(wdata32),
    .write_data_array(wda32), .fill_word(fw32), .victim_word(vw32),
    .write_tag_array(wta32), .fill_done(done32)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  // reference model: one miss in flight, described by its detection cycle
  bit m_active = 1'b0;
  int m_t0, m_got, m_base, m_mtag, m_vtag;

  // memory responder, indexed by absolute cycle
  bit        resp_v [0:2047];
  bit [15:0] resp_d [0:2047];
  bit        nv32;

  // per-test observations of the DUT
  int          wda_cnt, tag_cnt, done_k, last_busy_k;
  logic [15:0] req_a[$];
  bit          req_w[$];
  int          req_k[$];
  logic [31:0] q32[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void clear_obs();
    wda_cnt = 0; tag_cnt = 0; done_k = -1; last_busy_k = -1;
    req_a.delete(); req_w.delete(); req_k.delete(); q32.delete();
  endfunction

  task automatic sample();
    int k;
    logic e_busy, e_en, e_wr, e_wda, e_tag, e_done;
    logic [15:0] e_addr, e_wdata;
    int e_fw, e_vw;
    e_busy = 0; e_en = 0; e_wr = 0; e_wda = 0; e_tag = 0; e_done = 0;
    e_addr = 0; e_wdata = 0; e_fw = 0; e_vw = 0;
    if (rst) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      if (miss_detected) begin
        e_busy   = 1;
        m_active = 1'b1;
        m_t0     = cyc;
        m_got    = 0;
        m_mtag   = int'(miss_address) >> OFF_W;
        m_vtag   = int'(victim_tag);
        m_base   = (WB_EN && victim_dirty) ? WORDS : 0;
      end
    end else begin
      k = cyc - m_t0;
      e_busy = 1;
      if (k >= 1 && k <= m_base) begin
        e_en = 1; e_wr = 1; e_vw = k - 1;
        e_addr  = 16'((m_vtag * WORDS + (k - 1)) * BYTES);
        e_wdata = 16'hD000 | 16'(k - 1);
      end else if (k > m_base && k <= m_base + WORDS) begin
        e_en   = 1;
        e_addr = 16'((m_mtag * WORDS + (k - m_base - 1)) * BYTES);
      end
      if (k > m_base && memory_data_valid && m_got < WORDS) begin
        e_wda = 1; e_fw = m_got; m_got++;
        if (m_got == WORDS) begin
          e_tag = 1; e_done = 1; m_active = 1'b0;
        end
      end
    end
    chk("fsm_busy", 32'(fsm_busy), 32'(e_busy));
    chk("mem_enable", 32'(mem_enable), 32'(e_en));
    chk("mem_write", 32'(mem_write), 32'(e_wr));
    chk("memory_address", 32'(memory_address), 32'(e_addr));
    chk("memory_wdata", 32'(memory_wdata), 32'(e_wdata));
    chk("victim_word", 32'(victim_word), 32'(e_vw));
    chk("write_data_array", 32'(write_data_array), 32'(e_wda));
    chk("fill_word", 32'(fill_word), 32'(e_fw));
    chk("write_tag_array", 32'(write_tag_array), 32'(e_tag));
    chk("fill_done", 32'(fill_done), 32'(e_done));
    if (mem_enable) begin
      req_a.push_back(memory_address); req_w.push_back(mem_write); req_k.push_back(cyc - t0);
      if (!mem_write) begin
        resp_v[cyc + L] = 1'b1;
        resp_d[cyc + L] = memory_address ^ 16'h5A5A;
      end
    end
    wda_cnt += int'(write_data_array);
    tag_cnt += int'(write_tag_array);
    if (fill_done) done_k = cyc - t0;
    if (fsm_busy) last_busy_k = cyc - t0;
    if (en32) q32.push_back(maddr32);
    nv32 = en32 && !wr32;
  endtask

  task automatic clk_cycle();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    memory_data_valid = resp_v[cyc];
    memory_data       = resp_d[cyc];
    valid32           = nv32;
  endtask

  task automatic start_miss(input logic [15:0] a, input bit dirty, input logic [11:0] vt);
    clear_obs();
    miss_address = a; victim_dirty = dirty; victim_tag = vt;
    miss_detected = 1'b1; t0 = cyc;
    clk_cycle();
    miss_detected = 1'b0; victim_dirty = 1'b0;
  endtask

  initial begin
    int bad;
    rst = 1'b1; miss_detected = 1'b0; victim_dirty = 1'b0; victim_tag = '0;
    miss_address = '0; memory_data = '0; memory_data_valid = 1'b0;
    miss32 = 1'b0; addr32 = '0; valid32 = 1'b0; nv32 = 1'b0;
    clear_obs();
    repeat (3) clk_cycle();
    rst = 1'b0;
    clk_cycle();
    chk("reset_busy", 32'(fsm_busy), 32'd0);
    chk("reset_addr", 32'(memory_address), 32'd0);

    // clean miss at 0x1234
    start_miss(16'h1234, 1'b0, 12'h000);
    repeat (20) clk_cycle();
    chk("clean_nreq", req_a.size(), 8);
    if (req_a.size() == 8) begin
      chk("clean_first_addr", 32'(req_a[0]), 32'h1230);
      chk("clean_first_k", req_k[0], 1);
      chk("clean_last_addr", 32'(req_a[7]), 32'h123E);
      chk("clean_last_k", req_k[7], 8);
    end
    chk("clean_done_k", done_k, 12);
    chk("clean_last_busy_k", last_busy_k, 12);
    chk("clean_wda_cnt", wda_cnt, 8);

    // dirty miss: victim 0xABC, miss 0x0050
    start_miss(16'h0050, 1'b1, 12'hABC);
    repeat (30) clk_cycle();
    chk("dirty_nreq", req_a.size(), WB_EN ? 16 : 8);
    if (req_a.size() == (WB_EN ? 16 : 8)) begin
      chk("dirty_first_addr", 32'(req_a[0]), WB_EN ? 32'hABC0 : 32'h0050);
      chk("dirty_first_wr", 32'(req_w[0]), WB_EN ? 32'd1 : 32'd0);
      chk("dirty_read_addr", 32'(req_a[WB_EN ? 8 : 0]), 32'h0050);
      chk("dirty_read_k", req_k[WB_EN ? 8 : 0], WB_EN ? 9 : 1);
      chk("dirty_last_addr", 32'(req_a[WB_EN ? 15 : 7]), 32'h005E);
    end
    chk("dirty_done_k", done_k, WB_EN ? 20 : 12);

    // two stray valids after the last word
    start_miss(16'h2000, 1'b0, 12'h000);
    repeat (12) clk_cycle();
    memory_data_valid = 1'b1;
    clk_cycle();
    memory_data_valid = 1'b1;
    clk_cycle();
    repeat (4) clk_cycle();
    chk("stray_wda_cnt", wda_cnt, 8);
    chk("stray_tag_cnt", tag_cnt, 1);

    // reset in T5 of a fill
    start_miss(16'h3456, 1'b0, 12'h000);
    repeat (4) clk_cycle();
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    chk("rst_busy_next", 32'(fsm_busy), 32'd0);
    chk("rst_wda_next", 32'(write_data_array), 32'd0);
    clear_obs();
    repeat (12) clk_cycle();
    chk("rst_wda_after", wda_cnt, 0);
    chk("rst_tag_after", tag_cnt, 0);
    chk("rst_req_after", req_a.size(), 0);

    // second miss pulse in the middle of a fill
    start_miss(16'h4440, 1'b0, 12'h000);
    repeat (2) clk_cycle();
    miss_address = 16'h7770; miss_detected = 1'b1;
    clk_cycle();
    miss_detected = 1'b0;
    repeat (20) clk_cycle();
    bad = 0;
    foreach (req_a[i]) if (req_a[i][15:4] != 12'h444) bad++;
    chk("midmiss_nreq", req_a.size(), 8);
    chk("midmiss_foreign", bad, 0);
    chk("midmiss_tag_cnt", tag_cnt, 1);

    // 32-bit address, 32-bit data, 4 words
    clear_obs();
    addr32 = 32'h0000_1018; miss32 = 1'b1;
    clk_cycle();
    miss32 = 1'b0;
    repeat (10) clk_cycle();
    chk("w32_nreq", q32.size(), 4);
    if (q32.size() == 4) begin
      chk("w32_addr0", q32[0], 32'h1010);
      chk("w32_addr1", q32[1], 32'h1014);
      chk("w32_addr2", q32[2], 32'h1018);
      chk("w32_addr3", q32[3], 32'h101C);
    end
    chk("w32_idle", 32'(busy32), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
